// File: rtl/fifo_rd_stream.sv
// Read-side drainer for a single-clock FIFO with registered dout (1-cycle read latency).
// A 2-entry skid buffer absorbs the read latency and presents a valid/ready stream with burst framing.
module fifo_rd_stream #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [DW-1:0]    buf_mem [2];
  logic [1:0]       occ;
  logic             inflight;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] beat;

  logic       pop;
  logic [1:0] pend;
  logic       room;

  assign pop  = m_valid & m_ready;
  assign pend = occ + {1'b0, inflight};
  // Slot freed by this cycle's pop can be reused by the read issued now.
  assign room = pop ? (pend != 2'd3) : (pend < 2'd2);

  assign fifo_re = ~rst & en & ~fifo_empty & room;
  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign busy    = inflight | m_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= fifo_re;
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        beat   <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
    end
  end

  // Data storage needs no reset: m_data is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (inflight) buf_mem[wr_ptr] <= fifo_dout;
  end

endmodule
